sram_bus_arbiter: RTL and testbench

Shares the single 16-bit external SRAM between the CPU (8-bit, byte-addressed) and the VPU video fetcher. It sequences each byte access into SRAM strobe phases, steers byte lanes, grants alternately under contention, and stretches the CPU clock through `cpu_hold` while a CPU access is pending. It sits between the top-level address decode/paging logic and the SRAM pins. It replaces the combinational SRAM strobe generation and the VPU-driven hold.

---
 rtl/sram_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one 16-bit SRAM between the byte-wide CPU and the video
//            fetcher. It sequences the strobes, steers the byte lanes and
//            stretches the CPU clock. SRAM_ARB_WAITSTATE_EN adds a read phase
//            and a second write-pulse phase.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int ADDR_W = 21
) (
    input  logic              sys_clk,
    input  logic              btn_resetn,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_hold,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_ack,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic [1:0]        sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD1       = 3'd1,
        RD2       = 3'd2,
        RD3       = 3'd3,
        WR_SETUP  = 3'd4,
        WR_PULSE  = 3'd5,
        WR_PULSE2 = 3'd6,
        WR_HOLD   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_vid_q, gnt_vid_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cpu_rdata_q, vid_rdata_q;
    logic              ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
    logic [1:0]        dq_oe_q;

    logic              w_cpu_pend, w_vid_pend, w_pick_vid, w_capture;
    logic              w_rd_d, w_wr_d, w_we_d, w_act_d;
    logic [7:0]        w_byte;

    // The requester being acked in the done cycle still holds req; it is not a new request.
    assign w_cpu_pend = cpu_req & ~(done_q & ~gnt_vid_q);
    assign w_vid_pend = vid_req & ~(done_q & gnt_vid_q);

    always_comb begin
        state_d    = state_q;
        gnt_vid_d  = gnt_vid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        w_capture  = 1'b0;
        w_pick_vid = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_cpu_pend || w_vid_pend) begin
                    w_pick_vid = (w_cpu_pend && w_vid_pend) ? ~gnt_vid_q : w_vid_pend;
                    gnt_vid_d  = w_pick_vid;
                    addr_d     = w_pick_vid ? vid_addr : cpu_addr;
                    wdata_d    = cpu_wdata;
                    state_d    = (w_pick_vid || cpu_rw) ? RD1 : WR_SETUP;
                end
            end
            RD1: state_d = RD2;
            RD2: begin
`ifdef SRAM_ARB_WAITSTATE_EN
                state_d = RD3;
`else
                state_d   = IDLE;
                done_d    = 1'b1;
                w_capture = 1'b1;
`endif
            end
            RD3: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                w_capture = 1'b1;
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
`ifdef SRAM_ARB_WAITSTATE_EN
                state_d = WR_PULSE2;
`else
                state_d = WR_HOLD;
`endif
            end
            WR_PULSE2: state_d = WR_HOLD;
            WR_HOLD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight off flops.
    assign w_rd_d  = (state_d == RD1) || (state_d == RD2) || (state_d == RD3);
    assign w_we_d  = (state_d == WR_PULSE) || (state_d == WR_PULSE2);
    assign w_wr_d  = (state_d == WR_SETUP) || (state_d == WR_HOLD) || w_we_d;
    assign w_act_d = w_rd_d | w_wr_d;
    assign w_byte  = addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];

    always_ff @(posedge sys_clk or negedge btn_resetn) begin
        if (!btn_resetn) begin
            state_q     <= IDLE;
            gnt_vid_q   <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= 8'hFF;
            vid_rdata_q <= 8'hFF;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            gnt_vid_q <= gnt_vid_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ce_n_q    <= ~w_act_d;
            oe_n_q    <= ~w_rd_d;
            we_n_q    <= ~w_we_d;
            ub_n_q    <= ~(w_act_d & addr_d[0]);
            lb_n_q    <= ~(w_act_d & ~addr_d[0]);
            dq_oe_q   <= w_wr_d ? {addr_d[0], ~addr_d[0]} : 2'b00;
            if (w_capture) begin
                if (gnt_vid_q) begin
                    vid_rdata_q <= w_byte;
                end else begin
                    cpu_rdata_q <= w_byte;
                end
            end
        end
    end

    assign cpu_hold   = cpu_req & ~(done_q & ~gnt_vid_q);
    assign vid_ack    = done_q & gnt_vid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rdata  = vid_rdata_q;
    assign sram_addr  = addr_q[ADDR_W-1:1];
    assign sram_dq_o  = {wdata_q, wdata_q};
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Directed self-checking bench for sram_bus_arbiter with a small
//            behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

`ifdef SRAM_ARB_WAITSTATE_EN
    localparam int RD_LAT  = 4;
    localparam int WR_DONE = 5;
    localparam int WE_CYC  = 2;
`else
    localparam int RD_LAT  = 3;
    localparam int WR_DONE = 4;
    localparam int WE_CYC  = 1;
`endif

    logic        sys_clk = 1'b0;
    logic        btn_resetn;
    logic        cpu_req, cpu_rw;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_hold;
    logic        vid_req;
    logic [20:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic [1:0]  sram_dq_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] wr_a;
    logic [15:0] wr_d;
    logic [1:0]  wr_lanes;

    always #5 sys_clk = ~sys_clk;

    sram_bus_arbiter #(.ADDR_W(21)) dut (
        .sys_clk    (sys_clk),
        .btn_resetn (btn_resetn),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rdata  (vid_rdata),
        .vid_ack    (vid_ack),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        case (a)
            20'h00080: sram_word = 16'hA55A;
            20'h00000: sram_word = 16'h7788;
            20'h00003: sram_word = 16'h4411;
            20'h00100: sram_word = 16'h1234;
            default:   sram_word = 16'h0000;
        endcase
    endfunction

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_word(sram_addr) : 16'h0000;

    always @(posedge sys_clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            wr_a     <= sram_addr;
            wr_d     <= sram_dq_o;
            wr_lanes <= sram_dq_oe;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        btn_resetn = 1'b0;
        repeat (2) @(negedge sys_clk);
        btn_resetn = 1'b1;
        @(negedge sys_clk);
    endtask

    // Called at a falling edge; that cycle is T.
    task automatic cpu_read(input logic [20:0] a, input logic [7:0] exp, input string tag);
        int cnt;
        cpu_rw = 1'b1; cpu_addr = a; cpu_req = 1'b1;
        #1 check_val({tag, "_hold_T"}, cpu_hold, 1);
        cnt = 0;
        while (cpu_hold && cnt < 20) begin
            @(negedge sys_clk);
            cnt++;
            if (cnt == 1) begin
                check_val({tag, "_strb"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
                          {3'b001, ~a[0], a[0]});
                check_val({tag, "_addr"}, sram_addr, a[20:1]);
            end
        end
        check_val({tag, "_lat"}, cnt, RD_LAT);
        check_val({tag, "_data"}, cpu_rdata, exp);
        cpu_req = 1'b0;
    endtask

    initial begin
        int cnt, we_cnt, we_first, oe_cnt, hold_cnt, vack_cyc, n_ev;
        int ev_kind[6];
        int ev_time[6];

        btn_resetn = 1'b0;
        cpu_req = 0; cpu_rw = 1; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;
        do_reset();

        // Reset state
        check_val("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check_val("rst_dq_oe", sram_dq_oe, 2'b00);
        check_val("rst_hold", cpu_hold, 0);
        check_val("rst_vack", vid_ack, 0);
        check_val("rst_cpu_rdata", cpu_rdata, 8'hFF);
        check_val("rst_vid_rdata", vid_rdata, 8'hFF);
        check_val("rst_sram_addr", sram_addr, 0);

        // CPU read, upper lane
        cpu_read(21'h00101, 8'hA5, "rd_up");
        @(negedge sys_clk);
        check_val("rd_idle_ce", sram_ce_n, 1);

        // CPU write, lower lane
        cpu_rw = 1'b0; cpu_addr = 21'h00200; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        cnt = 0; we_cnt = 0; we_first = 0; oe_cnt = 0;
        #1;
        while (cpu_hold && cnt < 20) begin
            @(negedge sys_clk);
            cnt++;
            if (!sram_we_n) begin
                we_cnt++;
                if (we_first == 0) we_first = cnt;
            end
            if (!sram_oe_n) oe_cnt++;
            if (cnt == 1) begin
                check_val("wr_addr", sram_addr, 20'h00100);
                check_val("wr_lanes", {sram_ub_n, sram_lb_n}, 2'b10);
                check_val("wr_dq_oe", sram_dq_oe, 2'b01);
                check_val("wr_dq_o", sram_dq_o, 16'h3C3C);
            end
        end
        check_val("wr_done", cnt, WR_DONE);
        check_val("wr_we_cnt", we_cnt, WE_CYC);
        check_val("wr_we_first", we_first, 2);
        check_val("wr_no_oe", oe_cnt, 0);
        check_val("wr_mem_addr", wr_a, 20'h00100);
        check_val("wr_mem_lanes", wr_lanes, 2'b01);
        check_val("wr_mem_byte", wr_d[7:0], 8'h3C);
        cpu_req = 1'b0;
        @(negedge sys_clk);

        // Simultaneous requests after reset: video wins the first tie
        do_reset();
        vid_addr = 21'h00000; vid_req = 1'b1;
        cpu_rw = 1'b1; cpu_addr = 21'h00006; cpu_req = 1'b1;
        #1;
        cnt = 0; hold_cnt = 0; vack_cyc = 0;
        if (cpu_hold) hold_cnt++;
        while (cpu_hold && cnt < 30) begin
            @(negedge sys_clk);
            cnt++;
            if (vid_ack) begin
                vack_cyc = cnt;
                check_val("tie_vid_data", vid_rdata, 8'h88);
                vid_req = 1'b0;
            end
            if (cnt == RD_LAT + 1) begin
                check_val("tie_cpu_gnt_ce", sram_ce_n, 0);
                check_val("tie_cpu_gnt_addr", sram_addr, 20'h00003);
            end
            if (cpu_hold) hold_cnt++;
        end
        check_val("tie_vack_cyc", vack_cyc, RD_LAT);
        check_val("tie_hold_cnt", hold_cnt, 2 * RD_LAT);
        check_val("tie_cpu_data", cpu_rdata, 8'h11);
        cpu_req = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Continuous video plus repeated CPU reads: strict alternation
        vid_req = 1'b1; cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 21'h00006;
        cnt = 0; n_ev = 0;
        while (n_ev < 6 && cnt < 60) begin
            @(negedge sys_clk);
            cnt++;
            if (vid_ack) begin
                ev_kind[n_ev] = 1; ev_time[n_ev] = cnt; n_ev++;
            end else if (cpu_req && !cpu_hold) begin
                ev_kind[n_ev] = 0; ev_time[n_ev] = cnt; n_ev++;
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check_val("alt_n_events", n_ev, 6);
        for (int i = 0; i < n_ev; i++) begin
            check_val($sformatf("alt_kind_%0d", i), ev_kind[i], (i % 2 == 0) ? 1 : 0);
            check_val($sformatf("alt_time_%0d", i), ev_time[i], (i + 1) * RD_LAT);
        end
        repeat (RD_LAT + 1) @(negedge sys_clk);

        // Reset pulse during the write pulse
        cpu_rw = 1'b0; cpu_addr = 21'h00201; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_val("mid_we_low", sram_we_n, 0);
        check_val("mid_ub_low", sram_ub_n, 0);
        #1 btn_resetn = 1'b0;
        #1;
        check_val("mid_rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check_val("mid_rst_dq_oe", sram_dq_oe, 2'b00);
        check_val("mid_rst_no_ack", {cpu_hold, vid_ack}, 2'b10);
        @(negedge sys_clk);
        cpu_req = 1'b0;
        btn_resetn = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            check_val("post_rst_idle", {sram_ce_n, sram_we_n, cpu_hold, vid_ack}, 4'b1100);
        end
        cpu_read(21'h00101, 8'hA5, "post_rst_rd");
        repeat (2) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
